// File: rtl/pc_predictor_pkg.sv
// pc_predictor_pkg: shared widths, flush-mask bit positions and BTB counter encodings
//   ADDR_WIDTH      default fetch address width (word addressed)
//   BTB_ENTRIES     default branch target buffer depth
//   NUM_PIPE_MASKS  default width of the branch unit flush mask
//   PIPE_REG_*      bit positions inside the flush mask
//   ctr_e           2-bit saturating direction counter states
package pc_predictor_pkg;

    localparam int ADDR_WIDTH     = 16;
    localparam int BTB_ENTRIES    = 8;
    localparam int NUM_PIPE_MASKS = 4;

    localparam int PIPE_REG_PC    = 0;
    localparam int PIPE_REG_IF_ID = 1;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_predictor_btb.sv
// pc_predictor_btb: fully associative branch target buffer with 2-bit counters
//   clk, reset      clock; synchronous active-low reset clears valid bits and rp
//   lookup_pc       fetch address looked up combinationally
//   hit, predict    tag match / match with counter in a taken state
//   pred_target     target of the matching entry
//   ex_resolve      a conditional branch resolved in EX this cycle
//   ex_pc, ex_taken, ex_target  resolved branch address, outcome and taken target
module pc_predictor_btb #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BTB_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  hit,
    output logic                  predict,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  ex_resolve,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_taken,
    input  logic [ADDR_WIDTH-1:0] ex_target
);
    import pc_predictor_pkg::*;

    localparam int IW = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  tag_q    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  tag_d    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_q [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];
    logic [IW-1:0]          rp_q, rp_d;
    logic [IW-1:0]          hit_idx, ex_idx;
    logic                   ex_hit;

    // Two independent parallel compares: one for fetch, one for training.
    // Allocation only happens on a miss, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        ex_hit  = 1'b0;
        ex_idx  = '0;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == lookup_pc) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (valid_q[i] && tag_q[i] == ex_pc) begin
                ex_hit = 1'b1;
                ex_idx = IW'(i);
            end
        end
    end

    assign predict     = hit && ctr_q[hit_idx][1];
    assign pred_target = target_q[hit_idx];

    // Training uses pre-update state; the result is visible to lookup next cycle.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        rp_d     = rp_q;
        if (ex_resolve && ex_hit) begin
            ctr_d[ex_idx] = ex_taken ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
            if (ex_taken)
                target_d[ex_idx] = ex_target;
        end else if (ex_resolve && ex_taken) begin
            valid_d[rp_q]  = 1'b1;
            tag_d[rp_q]    = ex_pc;
            target_d[rp_q] = ex_target;
            ctr_d[rp_q]    = WT;
            rp_d           = rp_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            rp_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rp_q    <= rp_d;
        end
    end

    // Entry payload needs no reset: it is ignored while the valid bit is clear.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: rtl/pc_predictor.sv
// pc_predictor: fetch program counter, IF/ID prediction registers and next-PC mux
//   clk, reset          clock; synchronous active-low reset
//   stall               hold PC and IF/ID registers
//   flush               per-stage flush mask (PIPE_REG_PC, PIPE_REG_IF_ID used)
//   jump_address        redirect target when flush[PIPE_REG_PC] is set
//   ex_resolve, ex_pc, ex_taken, ex_target  BTB training from the EX stage
//   pc                  registered fetch address
//   if_id_pc            fetch address of the instruction in IF/ID
//   if_id_branch_taken  prediction made for that instruction
module pc_predictor #(
    parameter int ADDR_WIDTH     = pc_predictor_pkg::ADDR_WIDTH,
    parameter int BTB_ENTRIES    = pc_predictor_pkg::BTB_ENTRIES,
    parameter int NUM_PIPE_MASKS = pc_predictor_pkg::NUM_PIPE_MASKS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [NUM_PIPE_MASKS-1:0] flush,
    input  logic [ADDR_WIDTH-1:0]     jump_address,
    input  logic                      ex_resolve,
    input  logic [ADDR_WIDTH-1:0]     ex_pc,
    input  logic                      ex_taken,
    input  logic [ADDR_WIDTH-1:0]     ex_target,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic [ADDR_WIDTH-1:0]     if_id_pc,
    output logic                      if_id_branch_taken
);
    import pc_predictor_pkg::*;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
    logic                  if_id_bt_q, if_id_bt_d;
    logic                  btb_hit, btb_predict;
    logic [ADDR_WIDTH-1:0] btb_target;

    pc_predictor_btb #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc_q),
        .hit         (btb_hit),
        .predict     (btb_predict),
        .pred_target (btb_target),
        .ex_resolve  (ex_resolve),
        .ex_pc       (ex_pc),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target)
    );

    // Redirect beats stall, stall beats prediction; reset is applied in the flops.
    always_comb begin
        pc_d       = flush[PIPE_REG_PC] ? jump_address :
                     stall              ? pc_q         :
                     btb_predict        ? btb_target   : pc_q + ADDR_WIDTH'(1);
        if_id_pc_d = flush[PIPE_REG_IF_ID] ? '0   : stall ? if_id_pc_q : pc_q;
        if_id_bt_d = flush[PIPE_REG_IF_ID] ? 1'b0 : stall ? if_id_bt_q : btb_predict;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= '0;
            if_id_pc_q <= '0;
            if_id_bt_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_id_pc_q <= if_id_pc_d;
            if_id_bt_q <= if_id_bt_d;
        end
    end

    assign pc                 = pc_q;
    assign if_id_pc           = if_id_pc_q;
    assign if_id_branch_taken = if_id_bt_q;

    logic unused_hit;
    assign unused_hit = btb_hit;

endmodule
